// File: rtl/reservation_station_pkg.sv
// Shared widths, opcodes and operand/broadcast types for the reservation station.
// Also holds the wake-up rule shared by dispatch bypass and entry snooping.
package reservation_station_pkg;

  localparam int OP_LOG  = 5;
  localparam int ROB_LOG = 4;
  localparam int RS_SIZE = 16;
  localparam int RS_LOG  = 4;

  localparam logic [OP_LOG-1:0] OP_NOP = 5'd0;
  localparam logic [OP_LOG-1:0] OP_ADD = 5'd1;
  localparam logic [OP_LOG-1:0] OP_SUB = 5'd2;
  localparam logic [OP_LOG-1:0] OP_AND = 5'd3;
  localparam logic [OP_LOG-1:0] OP_OR  = 5'd4;
  localparam logic [OP_LOG-1:0] OP_XOR = 5'd5;
  localparam logic [OP_LOG-1:0] OP_BEQ = 5'd6;
  localparam logic [OP_LOG-1:0] OP_BNE = 5'd7;

  typedef struct packed {
    logic [31:0]        v;
    logic               r;
    logic [ROB_LOG-1:0] q;
  } opnd_t;

  typedef struct packed {
    logic               en;
    logic [31:0]        val;
    logic [ROB_LOG-1:0] tag;
  } bcast_t;

  typedef struct packed {
    logic [OP_LOG-1:0]  op;
    opnd_t              j;
    opnd_t              k;
    logic [31:0]        imm;
    logic [ROB_LOG-1:0] dest;
    logic [31:0]        pc;
  } rs_entry_t;

  // A waiting operand captures a matching broadcast; the FU bus wins a tie.
  function automatic opnd_t wake(opnd_t o, bcast_t b, bcast_t l);
    opnd_t res;
    res = o;
    if (!o.r) begin
      if (b.en && (b.tag == o.q)) begin
        res.v = b.val;
        res.r = 1'b1;
      end else if (l.en && (l.tag == o.q)) begin
        res.v = l.val;
        res.r = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, broadcast and issue signals of the reservation station.
// slave = the station itself, master = dispatcher/broadcast/FU side.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic               D_valid;
  logic [OP_LOG-1:0]  D_op;
  logic [31:0]        D_Vj, D_Vk;
  logic               D_Rj, D_Rk;
  logic [ROB_LOG-1:0] D_Qj, D_Qk;
  logic [31:0]        D_Imm, D_CurPC;
  logic [ROB_LOG-1:0] D_DestRob;

  logic               B_enable;
  logic [31:0]        B_value;
  logic [ROB_LOG-1:0] B_RobId;
  logic               L_enable;
  logic [31:0]        L_value;
  logic [ROB_LOG-1:0] L_RobId;

  logic               RS_full;
  logic               RS_valid;
  logic [OP_LOG-1:0]  RS_op;
  logic [31:0]        RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
  logic [ROB_LOG-1:0] RS_DestRob;

  modport slave (
    input  D_valid, D_op, D_Vj, D_Vk, D_Rj, D_Rk, D_Qj, D_Qk, D_Imm, D_CurPC, D_DestRob,
    input  B_enable, B_value, B_RobId, L_enable, L_value, L_RobId,
    output RS_full, RS_valid, RS_op, RS_Vj, RS_Vk, RS_Imm, RS_DestRob, RS_CurPC
  );

  modport master (
    output D_valid, D_op, D_Vj, D_Vk, D_Rj, D_Rk, D_Qj, D_Qk, D_Imm, D_CurPC, D_DestRob,
    output B_enable, B_value, B_RobId, L_enable, L_value, L_RobId,
    input  RS_full, RS_valid, RS_op, RS_Vj, RS_Vk, RS_Imm, RS_DestRob, RS_CurPC
  );

endinterface

// File: rtl/rs_select.sv
// Lowest-index priority encoder: reports whether any request is set and which one.
module rs_select #(
  parameter int N   = 16,
  parameter int LOG = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  output logic           o_found,
  output logic [LOG-1:0] o_idx
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found = 1'b1;
        o_idx   = LOG'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Holds dispatched ALU/branch ops until both operands are ready, snooping the FU and
// load/store broadcast buses, and issues the lowest-index ready entry once per cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy_in,
  input  logic                 clear,
  reservation_station_if.slave rs_bus
);

  logic [RS_SIZE-1:0] r_busy;
  rs_entry_t          r_ent [RS_SIZE];

  logic               r_valid;
  logic [OP_LOG-1:0]  r_op;
  logic [31:0]        r_vj, r_vk, r_imm, r_pc;
  logic [ROB_LOG-1:0] r_dest;

  logic [RS_SIZE-1:0] w_ready;
  logic               w_free_found, w_rdy_found, w_dispatch;
  logic [RS_LOG-1:0]  w_free_idx, w_rdy_idx;
  bcast_t             w_b, w_l;
  rs_entry_t          w_new;

  assign w_b = '{en: rs_bus.B_enable, val: rs_bus.B_value, tag: rs_bus.B_RobId};
  assign w_l = '{en: rs_bus.L_enable, val: rs_bus.L_value, tag: rs_bus.L_RobId};

  // Readiness comes only from registered operand state.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] & r_ent[i].j.r & r_ent[i].k.r;
    end
  end

  rs_select #(.N(RS_SIZE), .LOG(RS_LOG)) u_free_sel (
    .i_req   (~r_busy),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  rs_select #(.N(RS_SIZE), .LOG(RS_LOG)) u_rdy_sel (
    .i_req   (w_ready),
    .o_found (w_rdy_found),
    .o_idx   (w_rdy_idx)
  );

  assign w_dispatch = rs_bus.D_valid & w_free_found;

  always_comb begin
    w_new.op   = rs_bus.D_op;
    w_new.j    = wake('{v: rs_bus.D_Vj, r: rs_bus.D_Rj, q: rs_bus.D_Qj}, w_b, w_l);
    w_new.k    = wake('{v: rs_bus.D_Vk, r: rs_bus.D_Rk, q: rs_bus.D_Qk}, w_b, w_l);
    w_new.imm  = rs_bus.D_Imm;
    w_new.dest = rs_bus.D_DestRob;
    w_new.pc   = rs_bus.D_CurPC;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_valid <= 1'b0;
      r_op    <= OP_NOP;
      r_vj    <= '0;
      r_vk    <= '0;
      r_imm   <= '0;
      r_dest  <= '0;
      r_pc    <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_busy  <= '0;
        r_valid <= 1'b0;
        r_op    <= OP_NOP;
      end else begin
        r_valid <= w_rdy_found;
        if (w_rdy_found) begin
          r_op              <= r_ent[w_rdy_idx].op;
          r_vj              <= r_ent[w_rdy_idx].j.v;
          r_vk              <= r_ent[w_rdy_idx].k.v;
          r_imm             <= r_ent[w_rdy_idx].imm;
          r_dest            <= r_ent[w_rdy_idx].dest;
          r_pc              <= r_ent[w_rdy_idx].pc;
          r_busy[w_rdy_idx] <= 1'b0;
        end else begin
          r_op <= OP_NOP;
        end
        // The issued entry is busy and the dispatch target is free, so they never collide.
        if (w_dispatch) r_busy[w_free_idx] <= 1'b1;
      end
    end
  end

  // NOTE: entry payload is not reset; the busy bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (rdy_in && !clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          r_ent[i].j <= wake(r_ent[i].j, w_b, w_l);
          r_ent[i].k <= wake(r_ent[i].k, w_b, w_l);
        end
      end
      if (w_dispatch) r_ent[w_free_idx] <= w_new;
    end
  end

  assign rs_bus.RS_full    = &r_busy;
  assign rs_bus.RS_valid   = r_valid & rdy_in;
  assign rs_bus.RS_op      = r_op;
  assign rs_bus.RS_Vj      = r_vj;
  assign rs_bus.RS_Vk      = r_vk;
  assign rs_bus.RS_Imm     = r_imm;
  assign rs_bus.RS_DestRob = r_dest;
  assign rs_bus.RS_CurPC   = r_pc;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: directed scenarios plus randomized traffic compared every cycle
// against an instruction-level reference model of the reservation station.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst_n, rdy_in, clear;

  reservation_station_if u_if ();

  reservation_station dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rdy_in (rdy_in),
    .clear  (clear),
    .rs_bus (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: a list of waiting instructions and the last issued one.
  typedef struct {
    bit                 busy;
    logic [OP_LOG-1:0]  op;
    bit                 rj, rk;
    logic [31:0]        vj, vk, imm, pc;
    logic [ROB_LOG-1:0] qj, qk, dest;
  } m_ent_t;

  m_ent_t             m [RS_SIZE];
  bit                 e_valid;
  logic [OP_LOG-1:0]  e_op;
  logic [31:0]        e_vj, e_vk, e_imm, e_pc;
  logic [ROB_LOG-1:0] e_dest;

  task automatic m_reset();
    foreach (m[i]) m[i].busy = 1'b0;
    e_valid = 1'b0; e_op = OP_NOP;
    e_vj = '0; e_vk = '0; e_imm = '0; e_pc = '0; e_dest = '0;
  endtask

  function automatic bit m_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Returns {ready, value} for an operand after looking at this cycle's broadcasts.
  function automatic logic [32:0] resolve(bit r, logic [31:0] v, logic [ROB_LOG-1:0] q);
    if (r) return {1'b1, v};
    if (u_if.B_enable && u_if.B_RobId == q) return {1'b1, u_if.B_value};
    if (u_if.L_enable && u_if.L_RobId == q) return {1'b1, u_if.L_value};
    return {1'b0, v};
  endfunction

  task automatic model_step();
    int sel, fre;
    if (!rdy_in) return;
    if (clear) begin
      foreach (m[i]) m[i].busy = 1'b0;
      e_valid = 1'b0;
      e_op    = OP_NOP;
      return;
    end
    sel = -1;
    fre = -1;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (sel < 0 && m[i].busy && m[i].rj && m[i].rk) sel = i;
      if (fre < 0 && !m[i].busy) fre = i;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m[i].busy) begin
        {m[i].rj, m[i].vj} = resolve(m[i].rj, m[i].vj, m[i].qj);
        {m[i].rk, m[i].vk} = resolve(m[i].rk, m[i].vk, m[i].qk);
      end
    end
    if (sel >= 0) begin
      e_valid = 1'b1;
      e_op = m[sel].op; e_vj = m[sel].vj; e_vk = m[sel].vk;
      e_imm = m[sel].imm; e_pc = m[sel].pc; e_dest = m[sel].dest;
      m[sel].busy = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_op    = OP_NOP;
    end
    if (u_if.D_valid && fre >= 0) begin
      m[fre].busy = 1'b1;
      m[fre].op = u_if.D_op; m[fre].imm = u_if.D_Imm; m[fre].pc = u_if.D_CurPC;
      m[fre].dest = u_if.D_DestRob; m[fre].qj = u_if.D_Qj; m[fre].qk = u_if.D_Qk;
      {m[fre].rj, m[fre].vj} = resolve(u_if.D_Rj, u_if.D_Vj, u_if.D_Qj);
      {m[fre].rk, m[fre].vk} = resolve(u_if.D_Rk, u_if.D_Vk, u_if.D_Qk);
    end
  endtask

  task automatic compare();
    check("valid", 32'(u_if.RS_valid), 32'(e_valid & rdy_in));
    check("full", 32'(u_if.RS_full), 32'(m_full()));
    check("op", 32'(u_if.RS_op), 32'(e_op));
    if (e_valid && rdy_in) begin
      check("vj", u_if.RS_Vj, e_vj);
      check("vk", u_if.RS_Vk, e_vk);
      check("imm", u_if.RS_Imm, e_imm);
      check("pc", u_if.RS_CurPC, e_pc);
      check("dest", 32'(u_if.RS_DestRob), 32'(e_dest));
    end
  endtask

  // Inputs change at the falling edge; model and DUT both consume them at the rising edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    u_if.D_valid = 1'b0; u_if.B_enable = 1'b0; u_if.L_enable = 1'b0; clear = 1'b0;
  endtask

  task automatic set_disp(logic [OP_LOG-1:0] op, logic [31:0] vj, logic rj, logic [ROB_LOG-1:0] qj,
                          logic [31:0] vk, logic rk, logic [ROB_LOG-1:0] qk, logic [ROB_LOG-1:0] dest);
    u_if.D_valid = 1'b1; u_if.D_op = op;
    u_if.D_Vj = vj; u_if.D_Rj = rj; u_if.D_Qj = qj;
    u_if.D_Vk = vk; u_if.D_Rk = rk; u_if.D_Qk = qk;
    u_if.D_DestRob = dest; u_if.D_Imm = $urandom; u_if.D_CurPC = $urandom;
  endtask

  initial begin
    rst_n = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    u_if.D_valid = 1'b0; u_if.D_op = '0; u_if.D_Vj = '0; u_if.D_Vk = '0;
    u_if.D_Rj = 1'b0; u_if.D_Rk = 1'b0; u_if.D_Qj = '0; u_if.D_Qk = '0;
    u_if.D_Imm = '0; u_if.D_CurPC = '0; u_if.D_DestRob = '0;
    u_if.B_enable = 1'b0; u_if.B_value = '0; u_if.B_RobId = '0;
    u_if.L_enable = 1'b0; u_if.L_value = '0; u_if.L_RobId = '0;
    m_reset();

    #12;
    check("rst_valid", 32'(u_if.RS_valid), 32'd0);
    check("rst_op", 32'(u_if.RS_op), 32'(OP_NOP));
    check("rst_vj", u_if.RS_Vj, 32'd0);
    check("rst_dest", 32'(u_if.RS_DestRob), 32'd0);
    check("rst_full", 32'(u_if.RS_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ready dispatch: two-cycle latency, one-cycle pulse.
    set_disp(OP_ADD, 32'd5, 1'b1, '0, 32'd7, 1'b1, '0, 4'd3);
    tick(); idle_inputs();
    check("rd_lat1", 32'(u_if.RS_valid), 32'd0);
    tick();
    check("rd_valid", 32'(u_if.RS_valid), 32'd1);
    check("rd_vj", u_if.RS_Vj, 32'd5);
    check("rd_vk", u_if.RS_Vk, 32'd7);
    check("rd_dest", 32'(u_if.RS_DestRob), 32'd3);
    tick();
    check("rd_pulse", 32'(u_if.RS_valid), 32'd0);

    // Wakeup from the FU bus.
    set_disp(OP_SUB, 32'd0, 1'b0, 4'd2, 32'd1, 1'b1, '0, 4'd5);
    tick(); idle_inputs();
    u_if.B_enable = 1'b1; u_if.B_RobId = 4'd2; u_if.B_value = 32'h10;
    tick(); idle_inputs();
    check("wk_wait", 32'(u_if.RS_valid), 32'd0);
    tick();
    check("wk_valid", 32'(u_if.RS_valid), 32'd1);
    check("wk_vj", u_if.RS_Vj, 32'h10);

    // Bypass from the load/store bus at dispatch.
    set_disp(OP_XOR, 32'd3, 1'b1, '0, 32'd0, 1'b0, 4'd4, 4'd6);
    u_if.L_enable = 1'b1; u_if.L_RobId = 4'd4; u_if.L_value = 32'd9;
    tick(); idle_inputs();
    tick();
    check("bp_valid", 32'(u_if.RS_valid), 32'd1);
    check("bp_vk", u_if.RS_Vk, 32'd9);

    // Fill all entries, then wake 7 and 2 together.
    tick();
    for (int i = 0; i < RS_SIZE; i++) begin
      set_disp(OP_ADD, 32'd0, 1'b0, ROB_LOG'(i), 32'd1, 1'b1, '0, ROB_LOG'(i));
      tick();
    end
    idle_inputs();
    check("fill_full", 32'(u_if.RS_full), 32'd1);
    u_if.B_enable = 1'b1; u_if.B_RobId = 4'd7; u_if.B_value = 32'h77;
    u_if.L_enable = 1'b1; u_if.L_RobId = 4'd2; u_if.L_value = 32'h22;
    tick(); idle_inputs();
    tick();
    check("ord_first", 32'(u_if.RS_DestRob), 32'd2);
    check("ord_vj1", u_if.RS_Vj, 32'h22);
    check("ord_full", 32'(u_if.RS_full), 32'd0);
    tick();
    check("ord_second", 32'(u_if.RS_DestRob), 32'd7);
    check("ord_vj2", u_if.RS_Vj, 32'h77);

    // Flush with five busy entries and a concurrent (ready) dispatch.
    clear = 1'b1;
    tick(); idle_inputs();
    for (int i = 0; i < 5; i++) begin
      set_disp(OP_OR, 32'd0, 1'b0, ROB_LOG'(8 + i), 32'd0, 1'b1, '0, ROB_LOG'(i));
      tick();
    end
    set_disp(OP_ADD, 32'd1, 1'b1, '0, 32'd2, 1'b1, '0, 4'd9);
    clear = 1'b1;
    tick(); idle_inputs();
    check("fl_valid", 32'(u_if.RS_valid), 32'd0);
    check("fl_full", 32'(u_if.RS_full), 32'd0);
    for (int t = 8; t < 13; t++) begin
      u_if.B_enable = 1'b1; u_if.B_RobId = ROB_LOG'(t); u_if.B_value = 32'(t);
      tick(); idle_inputs();
      check("fl_noissue", 32'(u_if.RS_valid), 32'd0);
    end
    tick(); tick();

    // Asynchronous reset while an issue is being presented.
    for (int i = 0; i < 3; i++) begin
      set_disp(OP_AND, 32'd0, 1'b0, 4'd1, 32'd0, 1'b1, '0, ROB_LOG'(i));
      tick();
    end
    set_disp(OP_BEQ, 32'd4, 1'b1, '0, 32'd4, 1'b1, '0, 4'd12);
    tick(); idle_inputs();
    tick();
    check("ar_pre", 32'(u_if.RS_valid), 32'd1);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    check("ar_valid", 32'(u_if.RS_valid), 32'd0);
    check("ar_op", 32'(u_if.RS_op), 32'(OP_NOP));
    check("ar_full", 32'(u_if.RS_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    u_if.B_enable = 1'b1; u_if.B_RobId = 4'd1; u_if.B_value = 32'h5;
    tick(); idle_inputs();
    tick();
    check("ar_empty", 32'(u_if.RS_valid), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      idle_inputs();
      rdy_in = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 59) == 0);
      if (!m_full() && $urandom_range(0, 1) == 1)
        set_disp(OP_LOG'($urandom_range(1, 7)), $urandom, 1'($urandom_range(0, 1)),
                 ROB_LOG'($urandom), $urandom, 1'($urandom_range(0, 1)),
                 ROB_LOG'($urandom), ROB_LOG'($urandom));
      if ($urandom_range(0, 9) < 4) begin
        u_if.B_enable = 1'b1; u_if.B_RobId = ROB_LOG'($urandom); u_if.B_value = $urandom;
      end
      if ($urandom_range(0, 9) < 3) begin
        u_if.L_enable = 1'b1; u_if.L_RobId = ROB_LOG'($urandom); u_if.L_value = $urandom;
        if (u_if.B_enable && u_if.L_RobId == u_if.B_RobId) u_if.L_RobId = u_if.L_RobId + 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
